// File: rtl/frame_sync_ctrl.sv
// Frame-synchronous score/banner controller for the overlay draw units.
// Define FRAME_SYNC_FREEZE_EN to hold scores and depth while a banner is up.
module frame_sync_ctrl #(
    parameter int H_LAST        = 639,
    parameter int V_LAST        = 479,
    parameter int BANNER_FRAMES = 180,
    parameter int PHASE_FRAMES  = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vga_ready,
    input  logic [15:0] pixel_x,
    input  logic [15:0] pixel_y,
    input  logic [15:0] your_score_in,
    input  logic [15:0] their_score_in,
    input  logic [1:0]  game_state_in,
    input  logic [15:0] ball_z_in,
    input  logic        new_game_ack,
    output logic [15:0] your_score,
    output logic [15:0] their_score,
    output logic [3:0]  depth_bin,
    output logic [1:0]  banner_state,
    output logic [2:0]  rainbow_phase,
    output logic [15:0] frame_count,
    output logic        new_game_req
);

    localparam int BW = (BANNER_FRAMES > 1) ? $clog2(BANNER_FRAMES) : 1;
    localparam int PW = (PHASE_FRAMES > 1) ? $clog2(PHASE_FRAMES) : 1;

    typedef enum logic [1:0] {
        ST_PLAY,
        ST_SHOW,
        ST_WAIT
    } state_t;

    state_t        state_q, state_d;
    logic [15:0]   your_q, your_d;
    logic [15:0]   their_q, their_d;
    logic [3:0]    depth_q, depth_d;
    logic [1:0]    banner_q, banner_d;
    logic [2:0]    rainbow_q, rainbow_d;
    logic [15:0]   frames_q, frames_d;
    logic          req_q, req_d;
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic [PW-1:0] pcnt_q, pcnt_d;

    logic       eof;
    logic       hold;
    logic       win;
    logic [3:0] bin;

    assign eof = vga_ready
              && (pixel_x == 16'(H_LAST))
              && (pixel_y == 16'(V_LAST));

    assign win = (game_state_in == 2'b01) || (game_state_in == 2'b10);

`ifdef FRAME_SYNC_FREEZE_EN
    assign hold = (state_q != ST_PLAY);
`else
    assign hold = 1'b0;
`endif

    // Bins are 125 wide, centred on multiples of 125
    always_comb begin
        if (ball_z_in < 16'd63)       bin = 4'd0;
        else if (ball_z_in < 16'd188) bin = 4'd1;
        else if (ball_z_in < 16'd313) bin = 4'd2;
        else if (ball_z_in < 16'd438) bin = 4'd3;
        else if (ball_z_in < 16'd563) bin = 4'd4;
        else if (ball_z_in < 16'd688) bin = 4'd5;
        else if (ball_z_in < 16'd813) bin = 4'd6;
        else if (ball_z_in < 16'd938) bin = 4'd7;
        else                          bin = 4'd8;
    end

    always_comb begin
        state_d   = state_q;
        your_d    = your_q;
        their_d   = their_q;
        depth_d   = depth_q;
        banner_d  = banner_q;
        rainbow_d = rainbow_q;
        frames_d  = frames_q;
        req_d     = req_q;
        bcnt_d    = bcnt_q;
        pcnt_d    = pcnt_q;

        if (eof) begin
            frames_d = frames_q + 16'd1;
            if (!hold) begin
                your_d  = your_score_in;
                their_d = their_score_in;
                depth_d = bin;
            end
        end

        unique case (state_q)
            ST_PLAY: begin
                banner_d  = 2'b00;
                rainbow_d = 3'd0;
                if (eof && win) begin
                    banner_d = game_state_in;
                    bcnt_d   = BW'(BANNER_FRAMES - 1);
                    pcnt_d   = '0;
                    state_d  = ST_SHOW;
                end
            end
            ST_SHOW: begin
                if (eof) begin
                    if (pcnt_q == PW'(PHASE_FRAMES - 1)) begin
                        pcnt_d    = '0;
                        rainbow_d = rainbow_q + 3'd1;
                    end else begin
                        pcnt_d = pcnt_q + PW'(1);
                    end
                    if (bcnt_q == '0) begin
                        req_d   = 1'b1;
                        state_d = ST_WAIT;
                    end else begin
                        bcnt_d = bcnt_q - BW'(1);
                    end
                end
            end
            ST_WAIT: begin
                // Ack needs no eof and takes priority over win detection
                if (new_game_ack) begin
                    req_d     = 1'b0;
                    banner_d  = 2'b00;
                    rainbow_d = 3'd0;
                    state_d   = ST_PLAY;
                end
            end
            default: begin
                req_d     = 1'b0;
                banner_d  = 2'b00;
                rainbow_d = 3'd0;
                state_d   = ST_PLAY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_PLAY;
            your_q    <= '0;
            their_q   <= '0;
            depth_q   <= '0;
            banner_q  <= '0;
            rainbow_q <= '0;
            frames_q  <= '0;
            req_q     <= 1'b0;
            bcnt_q    <= '0;
            pcnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            your_q    <= your_d;
            their_q   <= their_d;
            depth_q   <= depth_d;
            banner_q  <= banner_d;
            rainbow_q <= rainbow_d;
            frames_q  <= frames_d;
            req_q     <= req_d;
            bcnt_q    <= bcnt_d;
            pcnt_q    <= pcnt_d;
        end
    end

    assign your_score    = your_q;
    assign their_score   = their_q;
    assign depth_bin     = depth_q;
    assign banner_state  = banner_q;
    assign rainbow_phase = rainbow_q;
    assign frame_count   = frames_q;
    assign new_game_req  = req_q;

endmodule

// File: tb/tb_frame_sync_ctrl.sv
// Bench for frame_sync_ctrl: vector table, hand sequences, random vs model.
// Two instances (BF=3/PF=1 and BF=20/PF=2) share one stimulus stream.
module tb_frame_sync_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        vga_ready;
    logic [15:0] pixel_x, pixel_y;
    logic [15:0] ys, ts, z;
    logic [1:0]  gs;
    logic        ack;

    logic [15:0] a_your, a_their, a_frames;
    logic [3:0]  a_depth;
    logic [1:0]  a_banner;
    logic [2:0]  a_rb;
    logic        a_req;
    logic [15:0] b_your, b_their, b_frames;
    logic [3:0]  b_depth;
    logic [1:0]  b_banner;
    logic [2:0]  b_rb;
    logic        b_req;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    frame_sync_ctrl #(
        .H_LAST(639), .V_LAST(479), .BANNER_FRAMES(3), .PHASE_FRAMES(1)
    ) dut_a (
        .clk(clk), .rst(rst), .vga_ready(vga_ready),
        .pixel_x(pixel_x), .pixel_y(pixel_y),
        .your_score_in(ys), .their_score_in(ts),
        .game_state_in(gs), .ball_z_in(z), .new_game_ack(ack),
        .your_score(a_your), .their_score(a_their), .depth_bin(a_depth),
        .banner_state(a_banner), .rainbow_phase(a_rb),
        .frame_count(a_frames), .new_game_req(a_req)
    );

    frame_sync_ctrl #(
        .H_LAST(639), .V_LAST(479), .BANNER_FRAMES(20), .PHASE_FRAMES(2)
    ) dut_b (
        .clk(clk), .rst(rst), .vga_ready(vga_ready),
        .pixel_x(pixel_x), .pixel_y(pixel_y),
        .your_score_in(ys), .their_score_in(ts),
        .game_state_in(gs), .ball_z_in(z), .new_game_ack(ack),
        .your_score(b_your), .their_score(b_their), .depth_bin(b_depth),
        .banner_state(b_banner), .rainbow_phase(b_rb),
        .frame_count(b_frames), .new_game_req(b_req)
    );

    // mode: 0 play, 1 banner shown, 2 waiting for ack; n = eofs seen in banner
    typedef struct {
        int mode; int n; int banner; int req; int rb;
        int your; int their; int depth; int frames;
    } mdl_t;

    mdl_t ma, mb;

    function automatic int zbin(int v);
        int b;
        if (v < 63) return 0;
        b = (v - 63) / 125 + 1;
        return (b > 8) ? 8 : b;
    endfunction

    function automatic mdl_t mzero();
        mdl_t r;
        r.mode = 0; r.n = 0; r.banner = 0; r.req = 0; r.rb = 0;
        r.your = 0; r.their = 0; r.depth = 0; r.frames = 0;
        return r;
    endfunction

    function automatic mdl_t upd(mdl_t m, int bf, int pf);
        mdl_t r;
        bit eof, frz;
        r = m;
        if (rst) return mzero();
        eof = vga_ready && pixel_x == 16'd639 && pixel_y == 16'd479;
`ifdef FRAME_SYNC_FREEZE_EN
        frz = (m.mode != 0);
`else
        frz = 1'b0;
`endif
        if (eof) begin
            r.frames = (m.frames + 1) % 65536;
            if (!frz) begin
                r.your = int'(ys); r.their = int'(ts); r.depth = zbin(int'(z));
            end
        end
        if (m.mode == 2 && ack) begin
            r.mode = 0; r.banner = 0; r.req = 0; r.n = 0;
        end else if (eof) begin
            if (m.mode == 0 && (gs == 2'd1 || gs == 2'd2)) begin
                r.mode = 1; r.banner = int'(gs); r.n = 0;
            end else if (m.mode == 1) begin
                r.n = m.n + 1;
                if (r.n == bf) begin r.mode = 2; r.req = 1; end
            end
        end
        r.rb = (r.mode == 0) ? 0 : (r.n / pf) % 8;
        return r;
    endfunction

    task automatic chk(string nm, int got, int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d @%0t", nm, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        ma = upd(ma, 3, 1);
        mb = upd(mb, 20, 2);
        #1;
        chk("A.your", int'(a_your), ma.your);
        chk("A.their", int'(a_their), ma.their);
        chk("A.depth", int'(a_depth), ma.depth);
        chk("A.banner", int'(a_banner), ma.banner);
        chk("A.rainbow", int'(a_rb), ma.rb);
        chk("A.frames", int'(a_frames), ma.frames);
        chk("A.req", int'(a_req), ma.req);
        chk("B.your", int'(b_your), mb.your);
        chk("B.their", int'(b_their), mb.their);
        chk("B.depth", int'(b_depth), mb.depth);
        chk("B.banner", int'(b_banner), mb.banner);
        chk("B.rainbow", int'(b_rb), mb.rb);
        chk("B.frames", int'(b_frames), mb.frames);
        chk("B.req", int'(b_req), mb.req);
    endtask

    task automatic eof_step(logic [1:0] g);
        vga_ready = 1'b1; pixel_x = 16'd639; pixel_y = 16'd479; gs = g;
        step();
    endtask

    task automatic idle_step();
        vga_ready = 1'b1; pixel_x = 16'd0; pixel_y = 16'd0;
        step();
    endtask

    typedef struct {
        logic        rdy;
        logic [15:0] px, py, sc, zz;
        int          e_your, e_depth;
    } vec_t;

    vec_t vt[12];

    initial begin
        ma = mzero(); mb = mzero();
        rst = 1'b1; vga_ready = 1'b0; pixel_x = '0; pixel_y = '0;
        ys = '0; ts = '0; z = '0; gs = '0; ack = 1'b0;
        step();
        chk("reset.your", int'(a_your), 0);
        chk("reset.req", int'(a_req), 0);
        chk("reset.frames", int'(b_frames), 0);
        rst = 1'b0;

        vt[0]  = '{1'b1, 16'd100, 16'd200, 16'd3, 16'd0,     0, 0};
        vt[1]  = '{1'b1, 16'd639, 16'd479, 16'd3, 16'd62,    3, 0};
        vt[2]  = '{1'b1, 16'd100, 16'd200, 16'd4, 16'd63,    3, 0};
        vt[3]  = '{1'b1, 16'd639, 16'd479, 16'd4, 16'd63,    4, 1};
        vt[4]  = '{1'b0, 16'd639, 16'd479, 16'd5, 16'd187,   4, 1};
        vt[5]  = '{1'b1, 16'd639, 16'd479, 16'd5, 16'd187,   5, 1};
        vt[6]  = '{1'b1, 16'd639, 16'd479, 16'd5, 16'd188,   5, 2};
        vt[7]  = '{1'b1, 16'd639, 16'd479, 16'd5, 16'd937,   5, 7};
        vt[8]  = '{1'b1, 16'd639, 16'd479, 16'd5, 16'd938,   5, 8};
        vt[9]  = '{1'b1, 16'd639, 16'd479, 16'd5, 16'd65535, 5, 8};
        vt[10] = '{1'b1, 16'd639, 16'd478, 16'd6, 16'd0,     5, 8};
        vt[11] = '{1'b1, 16'd638, 16'd479, 16'd6, 16'd0,     5, 8};
        for (int i = 0; i < 12; i++) begin
            vga_ready = vt[i].rdy; pixel_x = vt[i].px; pixel_y = vt[i].py;
            ys = vt[i].sc; z = vt[i].zz;
            step();
            chk($sformatf("vec%0d.your", i), int'(a_your), vt[i].e_your);
            chk($sformatf("vec%0d.depth", i), int'(a_depth), vt[i].e_depth);
        end

        // banner sequence on A: BF=3, PF=1
        eof_step(2'd2);
        chk("ban.state", int'(a_banner), 2);
        chk("ban.rb0", int'(a_rb), 0);
        eof_step(2'd0);
        chk("ban.rb1", int'(a_rb), 1);
        eof_step(2'd0);
        chk("ban.rb2", int'(a_rb), 2);
        chk("ban.req_lo", int'(a_req), 0);
        eof_step(2'd0);
        chk("ban.req_hi", int'(a_req), 1);
        idle_step();
        idle_step();
        chk("ban.req_held", int'(a_req), 1);
        ack = 1'b1; idle_step(); ack = 1'b0;
        chk("ban.ack_req", int'(a_req), 0);
        chk("ban.ack_state", int'(a_banner), 0);

        // ack coinciding with eof in WAIT
        eof_step(2'd1);
        chk("col.enter", int'(a_banner), 1);
        for (int i = 0; i < 3; i++) eof_step(2'd1);
        chk("col.req", int'(a_req), 1);
        ack = 1'b1; eof_step(2'd1); ack = 1'b0;
        chk("col.state", int'(a_banner), 0);
        chk("col.req_lo", int'(a_req), 0);
        eof_step(2'd1);
        chk("col.rewin", int'(a_banner), 1);

        // reset mid-WAIT, then stray ack in PLAY
        for (int i = 0; i < 3; i++) eof_step(2'd0);
        chk("rst.pre", int'(a_req), 1);
        rst = 1'b1; idle_step(); rst = 1'b0;
        chk("rst.req", int'(a_req), 0);
        chk("rst.banner", int'(a_banner), 0);
        chk("rst.your", int'(a_your), 0);
        chk("rst.frames", int'(a_frames), 0);
        ack = 1'b1; idle_step(); ack = 1'b0;
        chk("stray.req", int'(a_req), 0);
        chk("stray.banner", int'(a_banner), 0);

        // score change under the banner
        ys = 16'd10; eof_step(2'd0);
        chk("frz.base", int'(a_your), 10);
        eof_step(2'd1);
        ys = 16'd20; eof_step(2'd0);
`ifdef FRAME_SYNC_FREEZE_EN
        chk("frz.show", int'(a_your), 10);
`else
        chk("frz.show", int'(a_your), 20);
`endif

        for (int i = 0; i < 4000; i++) begin
            rst = ($urandom_range(0, 299) == 0);
            vga_ready = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 2) == 0) begin
                pixel_x = 16'd639; pixel_y = 16'd479;
            end else begin
                pixel_x = 16'($urandom_range(0, 639));
                pixel_y = 16'($urandom_range(0, 479));
            end
            ys = 16'($urandom);
            ts = 16'($urandom);
            z = ($urandom_range(0, 7) == 0) ? 16'($urandom)
                                            : 16'($urandom_range(0, 1100));
            gs = 2'($urandom_range(0, 3));
            ack = ($urandom_range(0, 3) == 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/frame_sync_ctrl.md
# frame_sync_ctrl

Frame-synchronous controller for the frame/score overlay. It samples score, game-state and ball-depth inputs only at the end-of-frame boundary, so the overlay never tears mid-frame. It also runs the win-banner sequence (show for a fixed number of frames, then request a new game over a req/ack handshake) and generates the rainbow phase used by the banner colouring. It sits between game logic and the overlay draw units and drives their score, highlight and banner inputs.

## Interface
Parameters:
- H_LAST, 639, last visible pixel_x
- V_LAST, 479, last visible pixel_y
- BANNER_FRAMES, 180, frames the win banner is shown before a new game is requested (≥1)
- PHASE_FRAMES, 8, frames per rainbow phase step (≥1)

Ports:
- clk  in  1  pixel-domain clock
- rst  in  1  reset, synchronous, active-high
- vga_ready  in  1  pixel enable; pixel_x/pixel_y valid when high
- pixel_x  in  16  current pixel column
- pixel_y  in  16  current pixel row
- your_score_in  in  16  raw local score
- their_score_in  in  16  raw remote score
- game_state_in  in  2  00 play, 01 P1 win, 10 P2 win, 11 reserved
- ball_z_in  in  16  raw ball depth
- new_game_ack  in  1  game logic has restarted
- your_score  out  16  frame-latched local score
- their_score  out  16  frame-latched remote score
- depth_bin  out  4  highlighted frame index, 0..8
- banner_state  out  2  00 none, 01 P1 banner, 10 P2 banner
- rainbow_phase  out  3  banner colour rotation
- frame_count  out  16  completed frames, wraps
- new_game_req  out  1  level request to game logic

## Operation
- eof strobe = vga_ready && pixel_x == H_LAST && pixel_y == V_LAST. All state updates below occur only on eof, except the ack handling.
- On eof:
  - your_score and their_score latch their inputs.
  - frame_count increments, wrapping mod 2^16.
  - depth_bin latches bin(ball_z_in): 0 for 0–62, 1 for 63–187, 2 for 188–312, 3 for 313–437, 4 for 438–562, 5 for 563–687, 6 for 688–812, 7 for 813–937, 8 for ≥938.
  - Bin comparisons are unsigned on all 16 bits.
- FSM states:
  - PLAY: banner_state = 00, rainbow_phase = 0. On eof with game_state_in 01 or 10: latch banner_state = game_state_in, load banner counter = BANNER_FRAMES − 1 and phase counter = 0, then go to SHOW. Code 11 is treated as 00.
  - SHOW: on each eof, if the banner counter is 0, assert new_game_req and go to WAIT. Otherwise decrement the banner counter. The phase counter counts eofs 0..PHASE_FRAMES−1; on wrap, rainbow_phase increments mod 8. game_state_in changes are ignored in this state.
  - WAIT: new_game_req held high, banner_state held. When new_game_ack is sampled high, on that cycle (no eof needed): drop new_game_req, clear banner_state and rainbow_phase, go to PLAY.
- If ack and eof coincide in WAIT: the ack wins. The next win can only be detected on a later eof.
- new_game_ack while not in WAIT is ignored.

## Timing
- All outputs are registered. Reset value of every output is 0; the FSM resets to PLAY and both counters reset to 0.
- Latency: outputs change on the clock edge that samples eof (1 cycle after the strobe pixel is presented).
- new_game_req rises on the edge sampling the BANNER_FRAMES-th eof after SHOW entry. It falls on the edge sampling ack high; minimum high time is 1 cycle.
- Reset asserted mid-SHOW or mid-WAIT returns to PLAY on the next edge, with the request dropped.

## Configuration
- FRAME_SYNC_FREEZE_EN defined: in SHOW and WAIT, your_score, their_score and depth_bin do not update on eof, so the final score stays frozen under the banner. frame_count still increments.
- FRAME_SYNC_FREEZE_EN undefined: these outputs latch on every eof in all states.

## Test plan
- Score latch: change your_score_in 3→4 at pixel (100,200) → your_score stays 3 until the edge sampling (639,479), then reads 4. Deasserting vga_ready at (639,479) → no update.
- Depth bins: drive ball_z 62, 63, 187, 188, 937, 938, 65535 across successive frames → depth_bin reads 0, 1, 1, 2, 7, 8, 8.
- Banner sequence, BANNER_FRAMES=3, PHASE_FRAMES=1:
  - game_state_in=10 at eof → banner_state=10.
  - rainbow_phase reads 1 and 2 after the next eofs.
  - new_game_req rises on the 3rd eof after entry.
  - ack 2 cycles later → req drops and banner_state=00 on that edge.
- Ack/eof collision: ack coincides with eof in WAIT while game_state_in=01 → PLAY, banner_state=00. The following eof → banner_state=01.
- Reset mid-WAIT → all outputs 0 on the next edge. A stray ack while in PLAY → no effect.
- Freeze: with FRAME_SYNC_FREEZE_EN, change the score during SHOW → your_score unchanged until after ack plus one eof. Without the macro → the score updates on the next eof.
